// File: rtl/i2s_audio_tx_if.sv
// Upstream sample path and serial output pins of the stereo I2S transmitter.
// The master side is the producer of samples and the consumer of the pins.
interface i2s_audio_tx_if;
    logic        sample_ce;
    logic [15:0] left;
    logic [15:0] right;
    logic        mute;
    logic        sclk;
    logic        lrclk;
    logic        sdata;
    logic        sample_req;
    logic        underrun;

    modport master (
        output sample_ce, left, right, mute,
        input  sclk, lrclk, sdata, sample_req, underrun
    );

    modport slave (
        input  sample_ce, left, right, mute,
        output sclk, lrclk, sdata, sample_req, underrun
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// Stereo I2S / left-justified transmitter with double-buffered 16-bit samples.
// Generates its own sclk/lrclk; one frame load per 2*SLOT_BITS bit clocks.
module i2s_audio_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned SLOT_BITS = 16,
    parameter bit          LJ_MODE   = 1'b0
) (
    input logic           clk,
    input logic           reset,
    i2s_audio_tx_if.slave bus
);
    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned DCW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BCW        = $clog2(FRAME_BITS);
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(FRAME_BITS - 1);
    localparam logic [BCW-1:0] SLOT_EDGE = BCW'(SLOT_BITS);

    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic                  sclk_q, sclk_d;
    logic [BCW-1:0]        bitcnt_q, bitcnt_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic                  sample_req_q, sample_req_d;
    logic                  underrun_q, underrun_d;
    logic [31:0]           hold_q, hold_d;
    logic                  pending_q, pending_d;
    logic [31:0]           last_q, last_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;

    logic                  tick;
    logic                  fall;
    logic                  load;
    logic [31:0]           sel;
    logic [FRAME_BITS-1:0] load_frame;

    always_comb begin
        tick   = (dcnt_q == DCNT_LAST);
        fall   = tick && sclk_q;
        load   = fall && (bitcnt_q == BIT_LAST);
        dcnt_d = tick ? '0 : dcnt_q + DCW'(1);
        sclk_d = sclk_q ^ tick;

        bitcnt_d = bitcnt_q;
        if (fall) begin
            bitcnt_d = load ? '0 : bitcnt_q + BCW'(1);
        end

        // Samples are left-aligned in their slots; unused LSBs stay zero.
        if (bus.mute) begin
            sel = '0;
        end else if (pending_q) begin
            sel = hold_q;
        end else begin
            sel = last_q;
        end
        load_frame = '0;
        load_frame[FRAME_BITS-1 -: 16] = sel[31:16];
        load_frame[SLOT_BITS-1 -: 16]  = sel[15:0];
        last_d = load ? sel : last_q;

        frame_d = frame_q;
        if (load) begin
            frame_d = load_frame;
        end else if (fall) begin
            frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
        end

        // I2S takes the pre-update MSB, which yields the one-bit data delay.
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        if (fall) begin
            lrclk_d = (bitcnt_d >= SLOT_EDGE) ^ LJ_MODE;
            sdata_d = LJ_MODE ? frame_d[FRAME_BITS-1] : frame_q[FRAME_BITS-1];
        end

        sample_req_d = load;
        underrun_d   = load && !pending_q && !bus.mute;
        hold_d       = bus.sample_ce ? {bus.left, bus.right} : hold_q;
        pending_d    = bus.sample_ce || (pending_q && !load);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q       <= '0;
            sclk_q       <= 1'b0;
            bitcnt_q     <= BIT_LAST;
            lrclk_q      <= ~LJ_MODE;
            sdata_q      <= 1'b0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
            hold_q       <= '0;
            pending_q    <= 1'b0;
            last_q       <= '0;
            frame_q      <= '0;
        end else begin
            dcnt_q       <= dcnt_d;
            sclk_q       <= sclk_d;
            bitcnt_q     <= bitcnt_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            sample_req_q <= sample_req_d;
            underrun_q   <= underrun_d;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            last_q       <= last_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.sclk       = sclk_q;
    assign bus.lrclk      = lrclk_q;
    assign bus.sdata      = sdata_q;
    assign bus.sample_req = sample_req_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Drives three transmitter configurations with one stimulus stream and compares
// every output each cycle against a frame-level arithmetic model.
module tb_i2s_audio_tx;
    localparam int NDUT = 3;
    localparam int CDV [NDUT] = '{2, 2, 3};
    localparam int SBV [NDUT] = '{16, 16, 24};
    localparam int LJV [NDUT] = '{0, 1, 1};
    localparam int FP0 = 4 * 2 * 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        ce    = 1'b0;
    logic [15:0] lin   = '0;
    logic [15:0] rin   = '0;
    logic        mute  = 1'b0;

    int checks = 0;
    int errors = 0;

    i2s_audio_tx_if bus0 ();
    i2s_audio_tx_if bus1 ();
    i2s_audio_tx_if bus2 ();

    assign bus0.sample_ce = ce;
    assign bus0.left      = lin;
    assign bus0.right     = rin;
    assign bus0.mute      = mute;
    assign bus1.sample_ce = ce;
    assign bus1.left      = lin;
    assign bus1.right     = rin;
    assign bus1.mute      = mute;
    assign bus2.sample_ce = ce;
    assign bus2.left      = lin;
    assign bus2.right     = rin;
    assign bus2.mute      = mute;

    i2s_audio_tx #(.CLK_DIV(2), .SLOT_BITS(16), .LJ_MODE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    i2s_audio_tx #(.CLK_DIV(2), .SLOT_BITS(16), .LJ_MODE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    i2s_audio_tx #(.CLK_DIV(3), .SLOT_BITS(24), .LJ_MODE(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    // Model: cycles since reset release, pending sample, frame on the wire and the one before it.
    int          mt    [NDUT];
    logic        mpend [NDUT];
    logic [31:0] mhold [NDUT];
    logic [31:0] mcur  [NDUT];
    logic [31:0] mprv  [NDUT];
    logic        mreq  [NDUT];
    logic        mund  [NDUT];

    function automatic logic bitval(input logic [31:0] f, input int sb, input int j);
        if (j < 16) return f[31-j];
        if (j >= sb && j < sb + 16) return f[15-(j-sb)];
        return 1'b0;
    endfunction

    function automatic int bitpos(input int d);
        int n;
        n = mt[d] / (2 * CDV[d]);
        return (n == 0) ? 2 * SBV[d] - 1 : (n - 1) % (2 * SBV[d]);
    endfunction

    function automatic int cycles_to_load0();
        int fl;
        fl = 2 * CDV[0];
        if (mt[0] < fl) return fl - mt[0];
        return FP0 - ((mt[0] - fl) % FP0);
    endfunction

    task automatic model_edge();
        for (int d = 0; d < NDUT; d++) begin
            if (reset) begin
                mt[d] = 0; mpend[d] = 1'b0; mhold[d] = '0; mcur[d] = '0; mprv[d] = '0;
                mreq[d] = 1'b0; mund[d] = 1'b0;
            end else begin
                int fl, fp;
                logic ld;
                mt[d] = mt[d] + 1;
                fl = 2 * CDV[d];
                fp = 4 * CDV[d] * SBV[d];
                ld = (mt[d] >= fl) && (((mt[d] - fl) % fp) == 0);
                mreq[d] = ld;
                mund[d] = ld && !mpend[d] && !mute;
                if (ld) begin
                    mprv[d] = mcur[d];
                    mcur[d] = mute ? 32'h0 : (mpend[d] ? mhold[d] : mcur[d]);
                    mpend[d] = 1'b0;
                end
                if (ce) begin
                    mhold[d] = {lin, rin};
                    mpend[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d t=%0d observed %0h expected %0h", tag, d, mt[d], obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            logic [4:0] o;
            int bc, n, esclk, elr;
            logic esd;
            case (d)
                0:       o = {bus0.sclk, bus0.lrclk, bus0.sdata, bus0.sample_req, bus0.underrun};
                1:       o = {bus1.sclk, bus1.lrclk, bus1.sdata, bus1.sample_req, bus1.underrun};
                default: o = {bus2.sclk, bus2.lrclk, bus2.sdata, bus2.sample_req, bus2.underrun};
            endcase
            n     = mt[d] / (2 * CDV[d]);
            bc    = bitpos(d);
            esclk = (mt[d] / CDV[d]) % 2;
            elr   = ((bc >= SBV[d]) ? 1 : 0) ^ LJV[d];
            if (n == 0) esd = 1'b0;
            else if (LJV[d] != 0) esd = bitval(mcur[d], SBV[d], bc);
            else if (bc == 0) esd = bitval(mprv[d], SBV[d], 2 * SBV[d] - 1);
            else esd = bitval(mcur[d], SBV[d], bc - 1);
            chk("sclk", d, {31'b0, o[4]}, esclk);
            chk("lrclk", d, {31'b0, o[3]}, elr);
            chk("sdata", d, {31'b0, o[2]}, {31'b0, esd});
            chk("sample_req", d, {31'b0, o[1]}, {31'b0, mreq[d]});
            chk("underrun", d, {31'b0, o[0]}, {31'b0, mund[d]});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_ce(input logic [15:0] l, input logic [15:0] r);
        ce = 1'b1; lin = l; rin = r;
        cycle();
        ce = 1'b0;
    endtask

    task automatic wait_load0(input int k);
        while (cycles_to_load0() != k) cycle();
    endtask

    task automatic first_req_latency();
        int cnt;
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (!bus0.sample_req && cnt < 50);
        chk("first_req_latency", 0, cnt, 4);
    endtask

    initial begin
        run(2);
        reset = 1'b0;
        first_req_latency();
        run(2 * FP0);

        wait_load0(10);
        pulse_ce(16'hA55A, 16'h8001);
        run(2 * FP0);

        wait_load0(1);
        pulse_ce(16'h1234, 16'hFEDC);
        run(2 * FP0);

        wait_load0(100);
        pulse_ce(16'h0F0F, 16'h7777);
        run(20);
        pulse_ce(16'hC3C3, 16'h0001);
        run(2 * FP0);

        pulse_ce(16'h5AA5, 16'h8888);
        wait_load0(60);
        mute = 1'b1;
        wait_load0(100);
        mute = 1'b0;
        pulse_ce(16'h4321, 16'hBEEF);
        run(2 * FP0);

        for (int i = 0; i < 4000; i++) begin
            ce  = ($urandom_range(0, 39) == 0);
            lin = 16'($urandom);
            rin = 16'($urandom);
            if ($urandom_range(0, 299) == 0) mute = ~mute;
            cycle();
        end
        ce = 1'b0;
        mute = 1'b0;
        pulse_ce(16'h7FFF, 16'h8000);
        run(FP0 + 20);

        while (bitpos(0) != 10) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        first_req_latency();
        pulse_ce(16'h2468, 16'h1357);
        run(2 * FP0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
